// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types shared across the MIPS core and its memory interface.
package cpu_types_pkg;

  // Status reported by the RAM model on its single port.
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage : cpu_types_pkg

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: grant-FSM states and defaults for the instruction/data RAM arbiter.
package mem_arb_pkg;

  // Arbiter grant state: idle, instruction fetch owns the port, data owns the port.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IGRANT = 2'b01,
    DGRANT = 2'b10
  } arb_state_t;

  // Default bound on how long a granted access may wait for the RAM.
  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

  // True while some requester owns the RAM port.
  function automatic logic is_grant(input arb_state_t s);
    return (s == IGRANT) || (s == DGRANT);
  endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: saturating cycle counter that flags an access stuck too long.
// Used by mem_arbiter only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Count enabled cycles since the last clear, holding once the limit is reached.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(LIMIT - 1));

endmodule : mem_arb_watchdog

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between instruction fetch and data
// load/store. Data has priority, but a waiting fetch always wins right after a
// data completion. RAM-side outputs come straight from registers latched at grant.
// Optional: define MEM_ARB_TIMEOUT_EN to abort grants the RAM never serves.
module mem_arbiter
  import cpu_types_pkg::*;
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  ramstate_t         ramstate,
  input  logic [DATA_W-1:0] ramload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              arb_err
);

  arb_state_t        state_q;
  logic              last_was_data_q;
  logic              arb_err_q;
  logic              ren_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;

  logic d_req;
  logic d_wins;
  logic ram_ready;
  logic ram_error;
  logic timeout;

  assign d_req     = dREN | dWEN;
  // Data goes first unless the previous completion was data and a fetch waits.
  assign d_wins    = d_req && !(last_was_data_q && iREN);
  assign ram_ready = (ramstate == ACCESS);
  assign ram_error = (ramstate == ERROR);

`ifdef MEM_ARB_TIMEOUT_EN
  logic wd_expired;

  mem_arb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .CLK      (CLK),
    .RST      (RST),
    .clr_i    (state_q == IDLE),
    .en_i     (is_grant(state_q) && !ram_ready),
    .expired_o(wd_expired)
  );

  assign timeout = is_grant(state_q) && wd_expired && !ram_ready;
`else
  // Without the watchdog a grant waits for the RAM indefinitely.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // Grant FSM: arbitrate in IDLE, latch the winner's request, release on completion/error/timeout.
  // NOTE: non-blocking assignments here so every register samples pre-edge values;
  // the async reset also clears the RAM enables without waiting for a clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= IDLE;
      last_was_data_q <= 1'b0;
      arb_err_q       <= 1'b0;
      ren_q           <= 1'b0;
      wen_q           <= 1'b0;
      addr_q          <= '0;
      store_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (d_wins) begin
            state_q <= DGRANT;
            addr_q  <= daddr;
            store_q <= dstore;
            ren_q   <= dREN & ~dWEN;  // a write wins over a simultaneous read
            wen_q   <= dWEN;
          end else if (iREN) begin
            state_q <= IGRANT;
            addr_q  <= iaddr;
            ren_q   <= 1'b1;
            wen_q   <= 1'b0;
          end
        end
        IGRANT, DGRANT: begin
          if (ram_ready) begin
            state_q         <= IDLE;
            ren_q           <= 1'b0;
            wen_q           <= 1'b0;
            last_was_data_q <= (state_q == DGRANT);
          end else if (ram_error) begin
            // The requester still holds its request, so the access is retried.
            state_q   <= IDLE;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            arb_err_q <= 1'b1;
          end else if (timeout) begin
            state_q         <= IDLE;
            ren_q           <= 1'b0;
            wen_q           <= 1'b0;
            arb_err_q       <= 1'b1;
            last_was_data_q <= (state_q == DGRANT);
          end
        end
        default: begin
          state_q <= IDLE;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  // Hits are combinational in the cycle the RAM reports ACCESS.
  assign ihit    = (state_q == IGRANT) && ram_ready;
  assign dhit    = (state_q == DGRANT) && ram_ready;
  assign iload   = ihit ? ramload : '0;
  assign dload   = dhit ? ramload : '0;
  assign arb_err = arb_err_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized fetch/data traffic against a
// cycle-level reference of the arbitration rules and a per-requester scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TO = 4;

  typedef struct {
    bit          chk;
    logic [31:0] val;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  ramstate_t   ramstate = FREE;
  logic        ramREN, ramWEN, ihit, dhit, arb_err;
  logic [31:0] ramaddr, ramstore, iload, dload;

  int   total = 0;
  int   bad   = 0;
  exp_t iq[$];
  exp_t dq[$];
  logic [31:0] ref_mem [256];
  logic [31:0] ram_mem [256];
  bit   ram_stop = 1'b0;

  // Reference-model state (sampled on the falling edge).
  bit          m_gr = 0, m_gdata = 0, m_lcd = 0, m_err = 0, m_done = 0;
  bit          p_ireq = 0, p_dreq = 0, p_dren = 0, p_dwen = 0;
  logic [31:0] p_iaddr = '0, p_daddr = '0, p_dstore = '0;
  bit          g_ren = 0, g_wen = 0;
  logic [31:0] g_addr = '0, g_store = '0;
  int          m_gcnt = 0;
  bit          exp_i, exp_d;
  exp_t        m_e;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .arb_err(arb_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_i(input bit chk, input logic [31:0] v);
    exp_t e;
    e.chk = chk; e.val = v;
    iq.push_back(e);
  endtask

  task automatic push_d(input bit chk, input logic [31:0] v);
    exp_t e;
    e.chk = chk; e.val = v;
    dq.push_back(e);
  endtask

  task automatic wait_hit(input string name, input bit is_data);
    bit got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge CLK);
      got = is_data ? dhit : ihit;
    end
    check(name, got, 1);
  endtask

  // Reference model + scoreboard monitor: predicts every grant from the requests
  // seen in the preceding idle cycle and checks port, hits, error flag and data.
  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (RST) begin
        m_gr = 0; m_lcd = 0; m_err = 0; m_done = 0;
      end else begin
        check("arb_err", arb_err, m_err);
        exp_i = 0; exp_d = 0;
        if (!m_gr) begin
          if (!m_done && (p_ireq || p_dreq)) begin
            m_gr = 1; m_gcnt = 0;
            m_gdata = p_dreq && !(m_lcd && p_ireq);
            if (m_gdata) begin
              g_addr = p_daddr; g_store = p_dstore; g_wen = p_dwen; g_ren = p_dren && !p_dwen;
            end else begin
              g_addr = p_iaddr; g_wen = 0; g_ren = 1;
            end
          end else begin
            check("idle_enables", {ramREN, ramWEN}, 0);
          end
        end
        m_done = 0;
        if (m_gr) begin
          check("ram_enables", {ramREN, ramWEN}, {g_ren, g_wen});
          check("ram_addr", ramaddr, g_addr);
          if (g_wen) check("ram_store", ramstore, g_store);
          m_gcnt++;
          if (ramstate == ACCESS) begin
            exp_i = !m_gdata; exp_d = m_gdata;
            m_gr = 0; m_done = 1; m_lcd = m_gdata;
          end else if (ramstate == ERROR) begin
            m_gr = 0; m_done = 1; m_err = 1;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (m_gcnt == TO) begin
            m_gr = 0; m_done = 1; m_err = 1; m_lcd = m_gdata;
          end
`endif
        end
        check("ihit", ihit, exp_i);
        check("dhit", dhit, exp_d);
        if (ihit) begin
          check("iq_has_entry", iq.size() > 0, 1);
          if (iq.size() > 0) begin
            m_e = iq.pop_front();
            if (m_e.chk) check("iload", iload, m_e.val);
          end
        end
        if (dhit) begin
          check("dq_has_entry", dq.size() > 0, 1);
          if (dq.size() > 0) begin
            m_e = dq.pop_front();
            if (m_e.chk) check("dload", dload, m_e.val);
          end
        end
      end
      p_ireq = iREN; p_dreq = dREN | dWEN; p_dren = dREN; p_dwen = dWEN;
      p_iaddr = iaddr; p_daddr = daddr; p_dstore = dstore;
    end
  end

  // RAM device: random BUSY latency, occasional ERROR, reads/writes its own array.
  task automatic ram_model();
    int busy = 0;
    bit act = 0, err = 0;
    while (!ram_stop) begin
      cyc();
      if (!(ramREN || ramWEN)) begin
        act = 0; ramstate = FREE;
      end else begin
        if (!act) begin
          act = 1; busy = $urandom_range(0, 2); err = ($urandom_range(0, 15) == 0);
        end
        if (busy > 0) begin
          busy--; ramstate = BUSY;
        end else if (err) begin
          ramstate = ERROR;
        end else begin
          ramstate = ACCESS;
          if (ramWEN) ram_mem[ramaddr[7:0]] = ramstore;
          else        ramload = ram_mem[ramaddr[7:0]];
        end
      end
    end
    ramstate = FREE;
  endtask

  task automatic i_requester(input int n);
    int a;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) cyc();
      a = $urandom_range(0, 127);
      iaddr = 32'(a); iREN = 1; push_i(1, ref_mem[a]);
      wait_hit("i_hit_wait", 0);
      cyc(); iREN = 0;
    end
  endtask

  task automatic d_requester(input int n);
    int a, kind;
    logic [31:0] v;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) cyc();
      a = $urandom_range(128, 255);
      kind = $urandom_range(0, 3);
      v = $urandom;
      daddr = 32'(a); dstore = v;
      if (kind < 2) begin
        dREN = 1; push_d(1, ref_mem[a]);
      end else begin
        ref_mem[a] = v; dWEN = 1; dREN = (kind == 3); push_d(0, '0);
      end
      wait_hit("d_hit_wait", 1);
      cyc(); dREN = 0; dWEN = 0;
    end
  endtask

  initial begin : stimulus
    int n;
    logic [31:0] v;
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ctrl", {ramREN, ramWEN, ihit, dhit, arb_err}, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    RST = 0;

    // Fetch with two BUSY cycles before ACCESS.
    cyc(); iREN = 1; iaddr = 32'h40; ramstate = BUSY; push_i(1, 32'h8C22_0004);
    n = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      if (c == 2) begin ramstate = ACCESS; ramload = 32'h8C22_0004; end
      if (ramREN && ramaddr == 32'h40) n++;
    end
    cyc(); iREN = 0; ramstate = FREE;
    check("t1_ren_cycles", n, 3);
    check("t1_back_to_idle", ramREN, 0);

    // Simultaneous fetch and store: data first, then the fetch despite a new load.
    cyc(); iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    ramstate = ACCESS; ramload = 32'h1111_1111;
    push_d(0, '0); push_i(1, 32'h1111_1111);
    cyc();
    check("t2_store_wen", ramWEN, 1);
    check("t2_store_data", ramstore, 32'hDEAD_BEEF);
    cyc(); dWEN = 0; dREN = 1; daddr = 32'h104; push_d(1, 32'h1111_1111);
    cyc();
    check("t2_fetch_after_data", {ramREN, ramWEN}, 2'b10);
    check("t2_fetch_addr", ramaddr, 32'h44);
    cyc(); iREN = 0;
    cyc();
    cyc(); dREN = 0;

    // Both held with an always-ready RAM: grants alternate.
    cyc(); iREN = 1; iaddr = 32'h50; dREN = 1; daddr = 32'h110; ramload = 32'h2222_2222;
    repeat (3) begin push_i(1, 32'h2222_2222); push_d(1, 32'h2222_2222); end
    repeat (12) cyc();
    iREN = 0; dREN = 0;
    cyc();
    check("t3_i_hits_done", iq.size(), 0);
    check("t3_d_hits_done", dq.size(), 0);

    // RAM stuck BUSY.
    iREN = 1; iaddr = 32'h4C; ramstate = BUSY;
    repeat (100) cyc();
`ifdef MEM_ARB_TIMEOUT_EN
    check("t5_timeout_err", arb_err, 1);
`else
    check("t5_grant_persists", {ramREN, ramWEN}, 2'b10);
    check("t5_grant_addr", ramaddr, 32'h4C);
    check("t5_no_err", arb_err, 0);
`endif
    ramload = 32'h3333_3333; ramstate = ACCESS; push_i(1, 32'h3333_3333);
    wait_hit("t5_hit_wait", 0);
    cyc(); iREN = 0; ramstate = FREE;

    // ERROR during a fetch grant: flag, no hit, retry.
    cyc(); iREN = 1; iaddr = 32'h48; ramstate = ERROR; ramload = 32'h4444_4444;
    push_i(1, 32'h4444_4444);
    cyc();
    cyc(); ramstate = ACCESS;
    check("t4_err_set", arb_err, 1);
    check("t4_idle_after_err", ramREN, 0);
    cyc();
    cyc(); iREN = 0; ramstate = FREE;
    check("t4_err_sticky", arb_err, 1);

    // Asynchronous reset in the middle of a data write grant.
    cyc(); dWEN = 1; daddr = 32'h108; dstore = 32'hCAFE_F00D; ramstate = BUSY;
    cyc();
    check("t6_wen_before_rst", ramWEN, 1);
    #2; RST = 1;
    #1;
    check("t6_enables_drop", {ramREN, ramWEN}, 0);
    check("t6_no_dhit", dhit, 0);
    #2; RST = 0;
    check("t6_err_cleared", arb_err, 0);
    ramstate = ACCESS; push_d(0, '0);
    wait_hit("t6_hit_wait", 1);
    cyc(); dWEN = 0; ramstate = FREE;

    // Randomized traffic from both requesters against the RAM device.
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      ram_mem[i] = v;
    end
    fork
      ram_model();
      begin
        fork
          i_requester(150);
          d_requester(150);
        join
        ram_stop = 1;
      end
    join

    repeat (4) cyc();
    check("iq_drained", iq.size(), 0);
    check("dq_drained", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : global_bound
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch requester and the data (load/store) requester of the MIPS core.
- Consumes iREN/dREN/dWEN as produced by the control unit.
- Drives ramREN/ramWEN/ramaddr/ramstore and returns ihit/dhit with load data.
- Sits between datapath/control and the RAM model; contains a 3-state grant FSM, a fairness flag and an access-latency watchdog.

Parameters:
- ADDR_W, 32, width of word addresses.
- DATA_W, 32, width of load/store data.
- TIMEOUT_CYCLES, 64, max cycles a granted access may wait for ramstate==ACCESS (watchdog only).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; one clock; reset is asynchronous and active-high.
- iREN  in  1  instruction read request; held until ihit.
- iaddr  in  ADDR_W  instruction address.
- dREN  in  1  data read request; held until dhit.
- dWEN  in  1  data write request; held until dhit.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  store data.
- ramstate  in  2  RAM status, ramstate_t: FREE, BUSY, ACCESS, ERROR.
- ramload  in  DATA_W  RAM read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ihit  out  1  one-cycle instruction completion.
- iload  out  DATA_W  fetched instruction, valid when ihit.
- dhit  out  1  one-cycle data completion.
- dload  out  DATA_W  load data, valid when dhit.
- arb_err  out  1  sticky error flag.

Behaviour:
- States: IDLE, IGRANT, DGRANT (arb_state_t). Reset → IDLE, last_was_data=0, arb_err=0.
- Reset values: all outputs 0, including ramaddr and ramstore.
- IDLE arbitration, evaluated each cycle:
  - dREN|dWEN pending, and not (last_was_data && iREN) → DGRANT.
  - else iREN → IGRANT.
  - else stay in IDLE.
- On grant, latch address, store data and read/write kind into registers. RAM outputs are driven only from these registers, so they are glitch-free and stable for the whole grant.
- DGRANT: ramREN=latched dREN, ramWEN=latched dWEN. If both dREN and dWEN are set, the write wins (ramREN=0).
- IGRANT: ramREN=1, ramWEN=0.
- In IDLE: ramREN=ramWEN=0.
- Completion: in a GRANT state with ramstate==ACCESS:
  - Assert the matching hit combinationally in that same cycle; pass ramload to iload/dload.
  - Next cycle return to IDLE; set last_was_data = (state==DGRANT).
- BUSY/FREE while granted: hold the state and keep RAM outputs unchanged.
- ramstate==ERROR while granted: set arb_err, no hit, return to IDLE. The requester still holds its request, so the access retries.
- Minimum latency: request at cycle N, grant at N+1, hit at N+1 if the RAM is ready. Back-to-back accesses need at least one IDLE cycle between them.
- Fairness: data has priority, except that a pending fetch always wins the arbitration immediately after a data completion. This bounds fetch starvation to one data access.
- Requester drops its request mid-grant: the access still completes on the latched values; the hit is issued anyway and the requester must ignore it. Verification checks that no RAM enable toggles mid-grant.
- Simultaneous iREN and dREN in IDLE with last_was_data=0: data is granted first.
- RST asserted mid-grant: immediate return to IDLE; RAM enables drop asynchronously.
- arb_err is cleared only by RST.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on each grant and increments each granted cycle without ACCESS.
  - When it reaches TIMEOUT_CYCLES-1, set arb_err, abort to IDLE with no hit, and set last_was_data as for a completion.
- Undefined: no counter; a grant waits indefinitely. TIMEOUT_CYCLES is unused.

Decomposition:
- ramstate_t already lives in cpu_types_pkg.
- New package mem_arb_pkg holds:
  - arb_state_t {IDLE, IGRANT, DGRANT}.
  - The default TIMEOUT_CYCLES constant.
- One sub-module, mem_arb_watchdog: counter with clear/enable/expired, instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C220004 → ramREN held 3 cycles at ramaddr 0x40, single-cycle ihit with iload=0x8C220004, then IDLE.
- iREN and dWEN raised together, daddr=0x100, dstore=0xDEADBEEF → DGRANT first, ramWEN=1, ramstore=0xDEADBEEF; after dhit, IGRANT even though dREN is re-raised.
- dREN and iREN held continuously, RAM always ACCESS → grants alternate D,I,D,I; no two consecutive data grants while iREN is pending.
- RAM returns ERROR during IGRANT → arb_err=1, no ihit, back to IDLE, retry granted; arb_err stays 1 until RST.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4, RAM stuck BUSY → abort after 4 granted cycles, arb_err=1; without the macro, the grant persists for 100 cycles.
- RST pulsed asynchronously mid-DGRANT → ramREN/ramWEN drop before the next CLK edge; state IDLE, no dhit.
